pll_lock_supervisor: RTL

- Sequences and supervises the system PLL from the reference-clock domain.
- Holds the PLL in reset for a fixed interval, then waits (with timeout) for `locked`, and filters it for stability.
- Only then releases the downstream synchronous reset. On loss of lock or a software request it re-runs the sequence; after repeated timeouts it parks in a fault state.
- Sits between the PLL wrapper's `rst`/`locked` pins and the SoC reset tree.

---
 rtl/pll_sup_pkg.sv | 30 +++
 rtl/sync_2ff.sv | 37 +++
 rtl/pll_lock_supervisor.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// ---------------------------------------------------------------------------
// pll_sup_pkg
//   Shared definitions for the PLL lock supervisor:
//   - state encoding of the sequencing FSM
//   - default timing constants (refclk cycles)
//   - small helper used to size the shared cycle counter
// ---------------------------------------------------------------------------
package pll_sup_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_PLL_RST   = 3'd0;
  localparam state_t S_WAIT_LOCK = 3'd1;
  localparam state_t S_STABLE    = 3'd2;
  localparam state_t S_RUN       = 3'd3;
  localparam state_t S_FAULT     = 3'd4;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 1000000;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES   = 3;

  // Largest of three interval lengths; sizes the counter that serves all of them.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer for quasi-static or slowly changing signals that
//   arrive asynchronously to clk. Each bit is synchronized independently.
//
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset, both stages clear to 0
//   i_d    : asynchronous input
//   o_q    : synchronized output (two clk edges of latency)
// ---------------------------------------------------------------------------
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // NOTE: non-blocking assignments so both stages sample their inputs from
  // before the edge; blocking here would collapse the chain into one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// ---------------------------------------------------------------------------
// pll_lock_supervisor
//   Sequences the system PLL from the reference clock domain: holds the PLL
//   in reset, waits (with timeout) for lock, filters lock for stability and
//   only then releases the downstream reset. Loss of lock or a relock request
//   re-runs the sequence; repeated timeouts park the PLL in FAULT.
//
//   refclk      : free-running reference clock, the only clock
//   rst_n       : asynchronous active-low reset
//   pll_locked  : PLL lock indication, asynchronous to refclk
//   relock_req  : one-cycle pulse, restart the PLL reset sequence
//   clear_fault : one-cycle pulse, leave FAULT / clear sticky lock_lost
//   pll_rst     : active-high PLL reset
//   sys_rst_n   : active-low downstream reset (released only in RUN)
//   pll_ok      : high only in RUN
//   fault       : high only in FAULT
//   lock_lost   : sticky, set when lock drops while in RUN
//   retry_cnt   : failed lock attempts since last RUN entry or fault clear
// ---------------------------------------------------------------------------
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int CNT_W         = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1,
  parameter int RETRY_W       = $clog2(MAX_RETRIES + 1) + 1
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               relock_req,
  input  logic               clear_fault,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               pll_ok,
  output logic               fault,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_cnt
);

  // Terminal counts: each interval of N cycles ends when cnt reaches N-1.
  localparam logic [CNT_W-1:0]   C_RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   C_STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] C_MAX_RETRIES  = RETRY_W'(MAX_RETRIES);

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [RETRY_W-1:0] r_retry;
  logic               r_lock_lost;
  logic               r_pll_rst;
  logic               r_sys_rst_n;
  logic               r_pll_ok;
  logic               r_fault;

  logic               w_locked_s;
  logic               w_restart;     // relock while already in PLL_RST
  logic               w_retry_inc;
  logic               w_cnt_clr;
  logic               w_pll_rst_d;
  logic               w_sys_rst_n_d;
  logic               w_pll_ok_d;
  logic               w_fault_d;
  logic               w_lock_lost_d;
  logic [RETRY_W-1:0] w_retry_d;

  // pll_locked is only ever consumed through this synchronizer.
  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .i_d   (pll_locked),
    .o_q   (w_locked_s)
  );

  // ---------------------------------------------------------------------
  // State register and shared interval counter
  // ---------------------------------------------------------------------
  assign w_cnt_clr = (w_next != r_state) || w_restart;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_PLL_RST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (r_state == S_PLL_RST || r_state == S_WAIT_LOCK ||
                   r_state == S_STABLE) begin
        // RUN and FAULT have no interval, so the counter rests there.
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next      = r_state;
    w_restart   = 1'b0;
    w_retry_inc = 1'b0;
    unique case (r_state)
      S_PLL_RST: begin
        if (relock_req) begin
          w_restart = 1'b1;
        end else if (r_cnt == C_RST_LAST) begin
          w_next = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        // A lock arriving on the timeout cycle still counts as a lock.
        if (relock_req) begin
          w_next = S_PLL_RST;
        end else if (w_locked_s) begin
          w_next = S_STABLE;
        end else if (r_cnt == C_TIMEOUT_LAST) begin
          if (r_retry == C_MAX_RETRIES) begin
            w_next = S_FAULT;
          end else begin
            w_next      = S_PLL_RST;
            w_retry_inc = 1'b1;
          end
        end
      end
      S_STABLE: begin
        if (relock_req) begin
          w_next = S_PLL_RST;
        end else if (!w_locked_s) begin
          w_next = S_WAIT_LOCK;
        end else if (r_cnt == C_STABLE_LAST) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        // No filtering in RUN: any low cycle of locked_s re-sequences.
        if (!w_locked_s || relock_req) begin
          w_next = S_PLL_RST;
        end
      end
      S_FAULT: begin
        if (clear_fault) begin
          w_next = S_PLL_RST;
        end
      end
      default: w_next = S_PLL_RST;
    endcase
  end

  // ---------------------------------------------------------------------
  // Output decode from next state (registered below)
  // ---------------------------------------------------------------------
  always_comb begin
    w_pll_rst_d   = (w_next == S_PLL_RST) || (w_next == S_FAULT);
    w_sys_rst_n_d = (w_next == S_RUN);
    w_pll_ok_d    = (w_next == S_RUN);
    w_fault_d     = (w_next == S_FAULT);

    // A lock drop in RUN beats a simultaneous clear_fault.
    w_lock_lost_d = r_lock_lost;
    if (r_state == S_RUN && !w_locked_s) begin
      w_lock_lost_d = 1'b1;
    end else if (clear_fault) begin
      w_lock_lost_d = 1'b0;
    end

    // Increments only below MAX_RETRIES, so the count saturates there.
    w_retry_d = r_retry;
    if (r_state == S_FAULT && clear_fault) begin
      w_retry_d = '0;
    end else if (r_state == S_STABLE && w_next == S_RUN) begin
      w_retry_d = '0;
    end else if (w_retry_inc) begin
      w_retry_d = r_retry + RETRY_W'(1);
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_pll_rst   <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_pll_ok    <= 1'b0;
      r_fault     <= 1'b0;
      r_lock_lost <= 1'b0;
      r_retry     <= '0;
    end else begin
      r_pll_rst   <= w_pll_rst_d;
      r_sys_rst_n <= w_sys_rst_n_d;
      r_pll_ok    <= w_pll_ok_d;
      r_fault     <= w_fault_d;
      r_lock_lost <= w_lock_lost_d;
      r_retry     <= w_retry_d;
    end
  end

  assign pll_rst   = r_pll_rst;
  assign sys_rst_n = r_sys_rst_n;
  assign pll_ok    = r_pll_ok;
  assign fault     = r_fault;
  assign lock_lost = r_lock_lost;
  assign retry_cnt = r_retry;

endmodule
